// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multicycle main controller for the MIPS datapath. A Moore FSM sequences
// fetch, decode, execute, memory and writeback; memory states optionally wait
// on a ready handshake and can abort after a bounded number of wait cycles.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   opcode_i[5:0]           instr[31:26] from the IR (sampled in DECODE only)
//   zero_i                  ALU zero flag (qualifies the branch PC write)
//   mem_ready_i             memory finished the current access this cycle
//   pc_write_o .. pc_src_o  datapath mux selects and write enables
//   state_o[3:0]            current state code, for debug
//   instr_done_o            pulse on the last cycle of each instruction
//   illegal_op_o            pulse in DECODE for an unsupported opcode
//   mem_timeout_o           pulse when a memory wait exceeds WAIT_LIMIT
//
// state   | meaning
// --------+---------------------------------------------------------
// FETCH   | 0  read instruction at PC, PC <= PC + 4 when ready
// DECODE  | 1  latch opcode, branch target into ALUOut, dispatch
// MEMADR  | 2  ALU computes load/store address
// MEMRD   | 3  load data read from memory
// MEMWB   | 4  MDR written to rt
// MEMWR   | 5  store data written to memory
// EXEC    | 6  R-type ALU operation
// ALUWB   | 7  ALUOut written to rd
// BRANCH  | 8  beq compare, PC <= ALUOut when equal
// IMMEXEC | 9  I-type ALU operation with immediate
// IMMWB   | 10 ALUOut written to rt
// JUMP    | 11 PC <= jump target

module mips_multicycle_ctrl #(
    parameter int          MEM_HANDSHAKE = 1,
    parameter int unsigned WAIT_LIMIT    = 0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic [3:0] state_o,
    output logic       instr_done_o,
    output logic       illegal_op_o,
    output logic       mem_timeout_o
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // Counter only needs to reach WAIT_LIMIT; with no limit it is a dummy bit.
    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    state_e          state_q, state_d;
    logic [5:0]      op_q, op_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

    logic            ready;
    logic            at_limit;
    logic [CW-1:0]   wait_inc;

    assign ready    = (MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;
    assign at_limit = (WAIT_LIMIT != 0) && (wait_cnt_q == CW'(WAIT_LIMIT));
    // Saturate so an unlimited wait never wraps back to a small count.
    assign wait_inc = (wait_cnt_q == {CW{1'b1}}) ? wait_cnt_q : wait_cnt_q + CW'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_FETCH;
            op_q       <= 6'b000000;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wait_cnt_d    = '0;
        pc_write_o    = 1'b0;
        iord_o        = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        mem_to_reg_o  = 1'b0;
        reg_dst_o     = 1'b0;
        reg_write_o   = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        alu_op_o      = 2'b00;
        pc_src_o      = 2'b00;
        instr_done_o  = 1'b0;
        illegal_op_o  = 1'b0;
        mem_timeout_o = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                if (ready) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end else if (at_limit) begin
                    // Refetch from the same PC; nothing is committed.
                    mem_timeout_o = 1'b1;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                op_d        = opcode_i;
                case (opcode_i)
                    OP_RTYPE:                    state_d = S_EXEC;
                    OP_LW, OP_SW:                state_d = S_MEMADR;
                    OP_BEQ:                      state_d = S_BRANCH;
                    OP_J:                        state_d = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_ANDI,
                    OP_ORI, OP_LUI:              state_d = S_IMMEXEC;
                    default: begin
                        illegal_op_o = 1'b1;
                        instr_done_o = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_o     = 1'b1;
                mem_read_o = 1'b1;
                if (ready) begin
                    state_d = S_MEMWB;
                end else if (at_limit) begin
                    mem_timeout_o = 1'b1;
                    instr_done_o  = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            S_MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
                if (ready) begin
                    instr_done_o = 1'b1;
                    state_d      = S_FETCH;
                end else if (at_limit) begin
                    mem_timeout_o = 1'b1;
                    instr_done_o  = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst_o    = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o  = 1'b1;
                alu_op_o     = 2'b01;
                pc_src_o     = 2'b01;
                pc_write_o   = zero_i;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_IMMEXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = (op_q == OP_ORI) ? 2'b11 : 2'b00;
                state_d     = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pc_src_o     = 2'b10;
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset is synchronous, so the current state may still be stale in the
        // reset cycle; force every strobe quiet regardless.
        if (reset_i) begin
            pc_write_o    = 1'b0;
            iord_o        = 1'b0;
            mem_read_o    = 1'b0;
            mem_write_o   = 1'b0;
            ir_write_o    = 1'b0;
            mem_to_reg_o  = 1'b0;
            reg_dst_o     = 1'b0;
            reg_write_o   = 1'b0;
            alu_src_a_o   = 1'b0;
            alu_src_b_o   = 2'b00;
            alu_op_o      = 2'b00;
            pc_src_o      = 2'b00;
            instr_done_o  = 1'b0;
            illegal_op_o  = 1'b0;
            mem_timeout_o = 1'b0;
        end
    end

    assign state_o = reset_i ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl (MEM_HANDSHAKE=1, WAIT_LIMIT=3). A path-based
// model predicts every output on every cycle; per-instruction state traces and
// pulse counts are also pinned against hand-written literals.

module tb_mips_multicycle_ctrl;

    localparam int WL = 3;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [5:0] opcode_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
    logic       mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
    logic [1:0] alu_src_b_o, alu_op_o, pc_src_o;
    logic [3:0] state_o;
    logic       instr_done_o, illegal_op_o, mem_timeout_o;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(1), .WAIT_LIMIT(WL)) dut (
        .clk_i(clk), .reset_i(reset_i), .opcode_i(opcode_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .iord_o(iord_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
        .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .pc_src_o(pc_src_o), .state_o(state_o), .instr_done_o(instr_done_o),
        .illegal_op_o(illegal_op_o), .mem_timeout_o(mem_timeout_o)
    );

    typedef struct packed {
        logic       pc_write, iord, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       instr_done, illegal_op, mem_timeout;
    } ctl_t;

    ctl_t act_c;
    assign act_c = {pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
                    mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
                    alu_src_b_o, alu_op_o, pc_src_o,
                    instr_done_o, illegal_op_o, mem_timeout_o};

    int total = 0;
    int bad   = 0;

    // Model: an instruction is the list of states it still has to visit.
    int         m_st   = 0;
    int         m_path[$];
    int         m_wait = 0;
    logic [5:0] m_op   = 6'b0;
    ctl_t       e;
    int         e_st;
    int         nx;
    logic       waits;

    // Per-run observations
    int tr[$];
    int exp_tr[$];
    int n_done, n_illegal, n_timeout, n_pcw, n_wr, imm_aluop;

    always @(negedge clk) begin
        e  = '0;
        nx = m_st;
        if (reset_i) begin
            e_st = 0;
            nx   = 0;
            m_path.delete();
            m_wait = 0;
        end else begin
            e_st = m_st;
            case (m_st)
                0:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; end
                1:  e.alu_src_b = 2'b11;
                2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
                3:  begin e.iord = 1'b1; e.mem_read = 1'b1; end
                4:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
                5:  begin e.iord = 1'b1; e.mem_write = 1'b1; end
                6:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
                7:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
                8:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01;
                          e.pc_write = zero_i; end
                9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                          e.alu_op = (m_op == 6'b001101) ? 2'b11 : 2'b00; end
                10: e.reg_write = 1'b1;
                11: begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
                default: ;
            endcase
            waits = (m_st == 0) || (m_st == 3) || (m_st == 5);
            if (m_st == 1) begin
                m_op = opcode_i;
                m_path.delete();
                case (opcode_i)
                    6'b000000: begin m_path.push_back(6); m_path.push_back(7); end
                    6'b100011: begin m_path.push_back(2); m_path.push_back(3); m_path.push_back(4); end
                    6'b101011: begin m_path.push_back(2); m_path.push_back(5); end
                    6'b000100: m_path.push_back(8);
                    6'b000010: m_path.push_back(11);
                    6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001111:
                        begin m_path.push_back(9); m_path.push_back(10); end
                    default: ;
                endcase
                if (m_path.size() == 0) begin
                    e.illegal_op = 1'b1;
                    e.instr_done = 1'b1;
                    nx = 0;
                end else begin
                    nx = m_path.pop_front();
                end
            end else if (waits && !mem_ready_i) begin
                if (m_wait == WL) begin
                    e.mem_timeout = 1'b1;
                    if (m_st != 0) e.instr_done = 1'b1;
                    nx = 0;
                    m_path.delete();
                    m_wait = 0;
                end else begin
                    m_wait = m_wait + 1;
                end
            end else begin
                m_wait = 0;
                if (m_st == 0) begin
                    e.ir_write = 1'b1;
                    e.pc_write = 1'b1;
                    nx = 1;
                end else if (m_path.size() == 0) begin
                    e.instr_done = 1'b1;
                    nx = 0;
                end else begin
                    nx = m_path.pop_front();
                end
            end
        end

        total++;
        if (act_c !== e) begin
            bad++;
            $display("FAIL outputs @%0t st=%0d: got %h want %h", $time, e_st, act_c, e);
        end
        total++;
        if (int'(state_o) != e_st) begin
            bad++;
            $display("FAIL state @%0t: got %0d want %0d", $time, state_o, e_st);
        end

        if (!reset_i) begin
            tr.push_back(int'(state_o));
            n_done    += int'(instr_done_o);
            n_illegal += int'(illegal_op_o);
            n_timeout += int'(mem_timeout_o);
            n_pcw     += int'(pc_write_o);
            n_wr      += int'(reg_write_o | mem_write_o);
            if (state_o == 4'd9) imm_aluop = int'(alu_op_o);
        end
        m_st = nx;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_trace(input string nm);
        logic  ok;
        string sa, se;
        ok = (tr.size() == exp_tr.size());
        if (ok) foreach (tr[i]) if (tr[i] != exp_tr[i]) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            sa = ""; se = "";
            foreach (tr[i]) sa = {sa, $sformatf("%0d ", tr[i])};
            foreach (exp_tr[i]) se = {se, $sformatf("%0d ", exp_tr[i])};
            $display("FAIL %s trace: got %s want %s", nm, sa, se);
        end
    endtask

    // Runs n cycles starting at a FETCH cycle; opcode switches to op_late from cycle 2.
    task automatic run(input string nm, input logic [5:0] op, input logic [5:0] op_late,
                       input int n, input logic [31:0] rdy, input logic z, input int exp_done);
        tr.delete();
        n_done = 0; n_illegal = 0; n_timeout = 0; n_pcw = 0; n_wr = 0; imm_aluop = -1;
        for (int i = 0; i < n; i++) begin
            opcode_i    = (i >= 2) ? op_late : op;
            mem_ready_i = rdy[i];
            zero_i      = z;
            @(posedge clk); #1;
        end
        chk_trace(nm);
        chk({nm, "_done"}, n_done, exp_done);
    endtask

    initial begin
        reset_i = 1'b1; opcode_i = 6'b0; zero_i = 1'b0; mem_ready_i = 1'b1;
        @(negedge clk); #1;
        chk("reset_state", int'(state_o), 0);
        chk("reset_mem_read", int'(mem_read_o), 0);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;

        exp_tr = {0, 1, 6, 7};
        run("rtype", 6'b000000, 6'b000000, 4, 32'hFFFF_FFFF, 1'b0, 1);

        exp_tr = {0, 1, 2, 3, 3, 3, 4};
        run("lw_wait", 6'b100011, 6'b100011, 7, 32'hFFFF_FFE7, 1'b0, 1);

        exp_tr = {0, 1, 8};
        run("beq_taken", 6'b000100, 6'b000100, 3, 32'hFFFF_FFFF, 1'b1, 1);
        chk("beq_taken_pcw", n_pcw, 2);
        run("beq_not", 6'b000100, 6'b000100, 3, 32'hFFFF_FFFF, 1'b0, 1);
        chk("beq_not_pcw", n_pcw, 1);

        exp_tr = {0, 1, 9, 10};
        run("ori", 6'b001101, 6'b001101, 4, 32'hFFFF_FFFF, 1'b0, 1);
        chk("ori_aluop", imm_aluop, 3);
        run("addi_latch", 6'b001000, 6'b000010, 4, 32'hFFFF_FFFF, 1'b0, 1);
        chk("addi_aluop", imm_aluop, 0);

        exp_tr = {0, 1};
        run("illegal", 6'b111111, 6'b111111, 2, 32'hFFFF_FFFF, 1'b0, 1);
        chk("illegal_pulse", n_illegal, 1);
        chk("illegal_writes", n_wr, 0);

        exp_tr = {0, 1, 2, 5, 5, 5, 5};
        run("sw_timeout", 6'b101011, 6'b101011, 7, 32'h0000_0001, 1'b0, 1);
        chk("sw_timeout_pulse", n_timeout, 1);

        exp_tr = {0, 1, 11};
        run("jump", 6'b000010, 6'b000010, 3, 32'hFFFF_FFFF, 1'b0, 1);

        exp_tr = {0, 1, 2, 5};
        run("sw", 6'b101011, 6'b101011, 4, 32'hFFFF_FFFF, 1'b0, 1);

        // Abort a store stuck in MEMWR with reset.
        run("sw_stuck", 6'b101011, 6'b101011, 4, 32'h0000_0001, 1'b0, 0);
        reset_i = 1'b1; mem_ready_i = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid_state", int'(state_o), 0);
        chk("rst_mid_mem_write", int'(mem_write_o), 0);
        chk("rst_mid_iord", int'(iord_o), 0);
        @(posedge clk); #1;
        reset_i = 1'b0; mem_ready_i = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_state", int'(state_o), 0);
        chk("post_rst_mem_read", int'(mem_read_o), 1);
        @(posedge clk); #1;

        exp_tr = {0, 1, 2, 3, 4};
        run("lw_after_rst", 6'b100011, 6'b100011, 5, 32'hFFFF_FFFF, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle successor to the single-cycle main decoder for the MIPS datapath.
- Replaces per-opcode combinational decode with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds a memory ready/wait handshake and illegal-opcode detection; configurable for zero-wait memories.
- Sits between the instruction register opcode field and the shared ALU, register file, memory and PC muxes.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- WAIT_LIMIT, 0: maximum wait cycles in any memory state before abort; 0 = unlimited.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_write  out  1  PC load enable.
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- mem_to_reg  out  1  register writeback source: 1 = MDR.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- alu_op  out  2  ALU op: 00 = add, 01 = sub, 10 = funct, 11 = ori.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state, for debug.
- instr_done  out  1  1-cycle pulse on the last cycle of each instruction.
- illegal_op  out  1  1-cycle pulse in DECODE when the opcode is unsupported.
- mem_timeout  out  1  1-cycle pulse when WAIT_LIMIT is exceeded.

Behaviour:
- Reset: synchronous, active-high, as already decided. On reset, state=FETCH(0) and the wait counter and latched opcode clear. While reset=1, every output is 0 except state=0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IMMEXEC=9, IMMWB=10, JUMP=11. Codes 12-15 go to FETCH on the next cycle with all outputs 0.
- Outputs are decoded from state only (Moore), except the zero/mem_ready-qualified terms below. Any output not listed for a state is 0.
- FETCH: mem_read=1, alu_src_b=01. When ready: ir_write=1, pc_write=1, go to DECODE; otherwise stay in FETCH.
- DECODE: alu_src_b=11. Latch opcode into an internal register; later states use only the latched copy. Next state:
  - 000000 -> EXEC
  - 100011, 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000, 001001, 001100, 001101, 001111 -> IMMEXEC
  - any other opcode -> illegal_op=1, instr_done=1, go to FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1, mem_read=1. Advance to MEMWB when ready.
- MEMWB: mem_to_reg=1, reg_write=1, instr_done=1 -> FETCH.
- MEMWR: iord=1, mem_write=1. When ready: instr_done=1 -> FETCH.
- EXEC: alu_src_a=1, alu_op=10 -> ALUWB.
- ALUWB: reg_dst=1, reg_write=1, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_write=zero, instr_done=1 -> FETCH.
- IMMEXEC: alu_src_a=1, alu_src_b=10, alu_op=11 if latched opcode is 001101, otherwise 00 -> IMMWB.
- IMMWB: reg_write=1, instr_done=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 -> FETCH.
- "Ready" means mem_ready=1, or always true when MEM_HANDSHAKE=0.
- Wait counter:
  - Counts consecutive not-ready cycles in FETCH, MEMRD and MEMWR; clears on leaving those states.
  - When WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT with still no ready: mem_timeout=1 and go to FETCH.
  - A timeout never asserts pc_write, ir_write or reg_write. In MEMRD or MEMWR a timeout also pulses instr_done.
- Latency with zero-wait memory: lw 5 cycles; sw, R-type, I-type 4; beq, j 3; illegal 2.
- Opcode changes outside DECODE are ignored.
- Reset asserted mid-instruction aborts it; the next cycle after reset deasserts is FETCH.

Test Plan:
- MEM_HANDSHAKE=1, mem_ready=1, opcode=000000 -> states 0,1,6,7,0. reg_dst=reg_write=1 in state 7; instr_done pulses once.
- lw (100011) with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. mem_to_reg=reg_write=1 only in state 4.
- beq (000100): zero=1 -> pc_write=1, pc_src=01 in BRANCH. Repeat with zero=0 -> pc_write=0 throughout BRANCH.
- ori (001101) -> alu_op=11 in IMMEXEC. addi (001000) -> alu_op=00. Change opcode to 000010 during IMMEXEC -> path unchanged.
- Opcode 111111 -> illegal_op and instr_done pulse in DECODE, back to FETCH, no write strobes asserted.
- WAIT_LIMIT=3, sw with mem_ready stuck at 0 -> mem_timeout after 3 wait cycles, returns to FETCH. Reset asserted in MEMWR -> state 0 and all strobes 0 the following cycle.
